// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared FSM state encodings and op codes for serial_addsub
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_addchunk.sv
// rtl/serial_addsub_addchunk.sv - CHUNK-bit ripple-carry slice built from adder1bit
//
// adder1bit: a, b, cin -> sum, cout (single full adder)
// addchunk : a[CHUNK], b[CHUNK], cin -> sum[CHUNK], cout (carry out of top bit),
//            c_msb (carry into top bit, used for signed overflow)

module adder1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module addchunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        adder1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle add/subtract processing CHUNK bits per clock
//
// Ports: clk, rst (async, active-high), start, op (0 add / 1 sub), a, b
//        -> busy, done (1-cycle pulse), result, carry (add carry / sub no-borrow),
//           overflow (signed), zero.

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cin;
    logic             slice_cout;
    logic             slice_cmsb;

    // Operands are shifted right each RUN cycle, so the active slice is always the low CHUNK bits.
    // The first slice takes its carry-in from the op bit (the +1 of two's-complement subtraction).
    assign slice_cin = (cnt_q == '0) ? op_q : c_q;

    addchunk #(.CHUNK(CHUNK)) u_addchunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (slice_cin),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        c_d        = c_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    op_d    = op;
                    c_d     = op;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d[cnt_q*CHUNK +: CHUNK] = slice_sum;
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = slice_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = ST_DONE;
                    carry_d    = slice_cout;
                    overflow_d = slice_cmsb ^ slice_cout;
                    zero_d     = (result_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            c_q        <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            c_q        <= c_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (WIDTH=16, CHUNK=4)
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    serial_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic o);
        exp_t        e;
        logic [16:0] s;
        logic [15:0] yy;
        yy    = o ? ~y : y;
        s     = {1'b0, x} + {1'b0, yy} + {16'd0, o};
        e.r   = s[15:0];
        e.c   = s[16];
        e.v   = (x[15] == yy[15]) && (s[15] != x[15]);
        e.z   = (s[15:0] == 16'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives start for one edge, pushes the expectation, returns just after edge T.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic o);
        start = 1'b1;
        a     = x;
        b     = y;
        op    = o;
        sb.push_back(model(x, y, o));
        @(negedge clk);
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
    endtask

    // Waits (bounded) for done, checks how many edges it took, then compares against the scoreboard.
    task automatic wait_done(input string tag, input int exp_lat);
        int   k;
        exp_t e;
        k = 0;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, exp_lat);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"},   {16'd0, result},   {16'd0, e.r});
            check({tag, " carry"},    {31'd0, carry},    {31'd0, e.c});
            check({tag, " overflow"}, {31'd0, overflow}, {31'd0, e.v});
            check({tag, " zero"},     {31'd0, zero},     {31'd0, e.z});
        end else begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        #1;
        check("reset busy",   {31'd0, busy},   32'd0);
        check("reset done",   {31'd0, done},   32'd0);
        check("reset result", {16'd0, result}, 32'd0);
        check("reset flags",  {29'd0, carry, overflow, zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0x00FF + 0x0001
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_done("add_ff_1", 4);
        check("add_ff_1 result const", {16'd0, result}, 32'h0100);
        @(negedge clk);
        check("idle after done", {30'd0, busy, done}, 32'd0);

        // 0xFFFF + 0x0001
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("add_ffff_1", 4);
        check("add_ffff_1 flags const", {29'd0, carry, overflow, zero}, 32'b101);
        @(negedge clk);
        check("flags hold", {29'd0, carry, overflow, zero}, 32'b101);

        // 0x7FFF + 0x0001 signed overflow
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done("add_7fff_1", 4);
        check("add_7fff_1 const", {13'd0, result, carry, overflow, zero}, {13'd0, 16'h8000, 3'b010});
        @(negedge clk);

        // 0x8000 - 0x0001
        start_op(16'h8000, 16'h0001, 1'b1);
        wait_done("sub_8000_1", 4);
        check("sub_8000_1 const", {13'd0, result, carry, overflow, zero}, {13'd0, 16'h7FFF, 3'b110});
        @(negedge clk);

        // 0x0003 - 0x0005
        start_op(16'h0003, 16'h0005, 1'b1);
        wait_done("sub_3_5", 4);
        check("sub_3_5 const", {13'd0, result, carry, overflow, zero}, {13'd0, 16'hFFFE, 3'b000});
        @(negedge clk);

        // start while busy is ignored
        start_op(16'h0001, 16'h0001, 1'b0);
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        op    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 3);
        check("busy_ignore const", {16'd0, result}, 32'h0002);
        // back-to-back: start in the done cycle
        start_op(16'h0010, 16'h0010, 1'b1);
        wait_done("b2b_sub", 4);
        check("b2b_sub const", {13'd0, result, carry, overflow, zero}, {13'd0, 16'h0000, 3'b101});
        @(negedge clk);

        // reset in the 2nd RUN cycle
        start_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy",   {31'd0, busy},   32'd0);
        check("midrst done",   {31'd0, done},   32'd0);
        check("midrst result", {16'd0, result}, 32'd0);
        check("midrst flags",  {29'd0, carry, overflow, zero}, 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            check("no done after rst", seen, 0);
        end

        // operation after reset
        start_op(16'hA5A5, 16'h5A5B, 1'b0);
        wait_done("post_rst_add", 4);
        @(negedge clk);
        start_op(16'h1234, 16'h4321, 1'b1);
        wait_done("post_rst_sub", 4);
        @(negedge clk);

        check("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
